// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle SLL/SRL/SRA by a variable amount, plus sign-extend-imm-and-shift-left-2 (SEXT2).
// Latency: L = ceil(shamt/STEP)+1 edges from accept to done (SEXT2 uses shamt=2); one op accepted every L+2 edges.
// Backpressure: start is only sampled in IDLE; starts seen while busy are dropped. Build option SEQ_SHIFT_FAST_EN gives STEP=4, otherwise STEP=1.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [IMM_W-1:0]   imm,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        OP_SLL   = 2'b00,
        OP_SRL   = 2'b01,
        OP_SRA   = 2'b10,
        OP_SEXT2 = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    op_e                r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_cnt_zero;
    logic [SHAMT_W-1:0] w_step;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_imm_sext;
    logic [WIDTH-1:0]   w_acc_init;
    logic [SHAMT_W-1:0] w_cnt_init;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_cnt_zero = (r_cnt == '0);

    // Immediate widened by replicating its top bit.
    assign w_imm_sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};

    // SEXT2 ignores operand/shamt entirely and always shifts by two.
    assign w_acc_init = (op_e'(op) == OP_SEXT2) ? w_imm_sext : operand;
    assign w_cnt_init = (op_e'(op) == OP_SEXT2) ? SHAMT_W'(2) : shamt;

`ifdef SEQ_SHIFT_FAST_EN
    // Up to four bit positions per cycle; the last step takes whatever remains.
    localparam int STEP = 4;
    localparam logic [SHAMT_W-1:0] STEP_V = SHAMT_W'(STEP);
    assign w_step = (r_cnt > STEP_V) ? STEP_V : r_cnt;
`else
    // One bit position per cycle; only used while the count is non-zero.
    assign w_step = SHAMT_W'(1);
`endif

    // One shift step of the accumulator; SRA replicates the current MSB, which equals the original sign.
    always_comb begin
        w_shifted = r_acc;
        case (r_op)
            OP_SLL,
            OP_SEXT2: w_shifted = r_acc << w_step;
            OP_SRL:   w_shifted = r_acc >> w_step;
            OP_SRA:   w_shifted = $unsigned($signed(r_acc) >>> w_step);
            default:  w_shifted = r_acc;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: shift until the count drains, report for one cycle, then return to idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_cnt_zero) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, step while counting, publish result when the count is exhausted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_SLL;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= op_e'(op);
            r_acc <= w_acc_init;
            r_cnt <= w_cnt_init;
        end else if (r_state == ST_SHIFT) begin
            if (w_cnt_zero) begin
                r_result <= r_acc;
            end else begin
                r_acc <= w_shifted;
                r_cnt <= r_cnt - w_step;
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: transaction-level reference model plus directed vectors.
// The model predicts busy/done/result per cycle from accept time and L = ceil(shamt/STEP)+1.
// Directed vectors also pin hand-computed results and latencies.
module tb_seq_shift_unit;

`ifdef SEQ_SHIFT_FAST_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests;
    int fails;
    int cyc;
    int acc_cyc;
    bit chk_en;

    // Model state: m_k counts edges since accept (0 = idle).
    int          m_k;
    int          m_L;
    logic [31:0] m_pend;
    logic [31:0] m_res;

    seq_shift_unit #(.WIDTH(32), .IMM_W(16), .SHAMT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .operand (operand),
        .imm     (imm),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                                 input logic [15:0] i, input logic [4:0] s);
        logic [31:0] sx;
        sx = {{16{i[15]}}, i};
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return sx << 2;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [4:0] s);
        int n;
        n = (o == 2'b11) ? 2 : int'(s);
        return (n + STEP - 1) / STEP + 1;
    endfunction

    // Reference timeline: accept when idle, done at edge L after accept, idle one edge later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k   <= 0;
            m_L   <= 0;
            m_res <= '0;
        end else if (m_k == 0) begin
            if (start) begin
                m_k    <= 1;
                m_pend <= model_result(op, operand, imm, shamt);
                m_L    <= model_lat(op, shamt);
            end
        end else if (m_k == m_L + 1) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_k == m_L) m_res <= m_pend;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",   {31'd0, busy}, {31'd0, (m_k != 0)});
            check("cyc_done",   {31'd0, done}, {31'd0, (m_k == m_L + 1)});
            check("cyc_result", result, m_res);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [15:0] i,
                         input logic [4:0] s);
        @(negedge clk);
        start = 1'b1; op = o; operand = a; imm = i; shamt = s;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        start = 1'b0; operand = $urandom; imm = 16'($urandom); shamt = 5'($urandom);
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp_res, input int exp_L);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done within 200 cycles, expected done after %0d", name, exp_L);
        end else begin
            check({name, "_lat"}, 32'(cyc - acc_cyc), 32'(exp_L));
            check({name, "_res"}, result, exp_res);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  q[$];
        bit  seen;
        tests = 0; fails = 0; cyc = 0; acc_cyc = 0; chk_en = 1'b0;
        start = 1'b0; op = 2'b00; operand = '0; imm = '0; shamt = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // SLL: 0xFFFFFFFF << 2.
        issue(2'b00, 32'hFFFF_FFFF, 16'h1234, 5'd2);
        check("sll_busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done("sll2", 32'hFFFF_FFFC, (STEP == 4) ? 2 : 3);

        // SEXT2 with garbage operand/shamt.
        issue(2'b11, 32'hDEAD_BEEF, 16'hF00F, 5'd29);
        wait_done("sext2_neg", 32'hFFFF_C03C, (STEP == 4) ? 2 : 3);
        issue(2'b11, 32'h5A5A_A5A5, 16'h0007, 5'd17);
        wait_done("sext2_pos", 32'h0000_001C, (STEP == 4) ? 2 : 3);

        // SRA vs SRL by 31.
        issue(2'b10, 32'h8000_0000, 16'h0000, 5'd31);
        wait_done("sra31", 32'hFFFF_FFFF, (STEP == 4) ? 9 : 32);
        issue(2'b01, 32'h8000_0000, 16'h0000, 5'd31);
        wait_done("srl31", 32'h0000_0001, (STEP == 4) ? 9 : 32);

        // shamt 0.
        issue(2'b00, 32'h1234_5678, 16'hFFFF, 5'd0);
        wait_done("sh0", 32'h1234_5678, 1);

        // start held high: accepts on edges 1,4,7 so done after edges 2,5,8.
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand = 32'h1234_5678; shamt = 5'd0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (done) q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("hold_done_count", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            check("hold_done0", 32'(q[0]), 32'd2);
            check("hold_done1", 32'(q[1]), 32'd5);
            check("hold_done2", 32'(q[2]), 32'd8);
        end
        check("hold_result", result, 32'h1234_5678);
        @(posedge clk);
        #1;

        // Second start mid-SHIFT must be ignored.
        issue(2'b00, 32'h0000_0ABC, 16'h0000, 5'd20);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 5'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("midstart", 32'hABC0_0000, (STEP == 4) ? 6 : 21);

        // Reset mid-SHIFT aborts; no done follows.
        issue(2'b01, 32'hF000_0000, 16'h0000, 5'd20);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",   {31'd0, busy}, 32'd0);
        check("midrst_done",   {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", {31'd0, seen}, 32'd0);
        issue(2'b01, 32'hF000_0000, 16'h0000, 5'd20);
        wait_done("post_rst_srl20", 32'h0000_0F00, (STEP == 4) ? 6 : 21);

        // A couple of extra patterns for the model.
        issue(2'b10, 32'h7000_0001, 16'h0000, 5'd5);
        wait_done("sra5_pos", 32'h0380_0000, (STEP == 4) ? 3 : 6);
        issue(2'b10, 32'h9000_0000, 16'h0000, 5'd4);
        wait_done("sra4_neg", 32'hF900_0000, (STEP == 4) ? 2 : 5);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
